// File: rtl/macro_rom_incr5.sv
// -----------------------------------------------------------------------------
// macro_rom_incr5
//   5-bit unsigned increment implemented as a 32-entry lookup ROM. Used to
//   advance the read and write pointers of macro_fifo32_incr. The carry-out
//   marks the 31 -> 0 rollover so the caller can toggle its wrap bit.
//
// Ports
//   d  input  [4:0]  current pointer value
//   q  output [4:0]  d + 1 mod 32
//   c  output        1 only when d == 31 (rollover)
// -----------------------------------------------------------------------------
module macro_rom_incr5 (
    input  logic [4:0] d,
    output logic [4:0] q,
    output logic       c
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the case can leave it unassigned (no latch).
        q = 5'd0;
        c = 1'b0;
        case (d)
            5'd0:  q = 5'd1;
            5'd1:  q = 5'd2;
            5'd2:  q = 5'd3;
            5'd3:  q = 5'd4;
            5'd4:  q = 5'd5;
            5'd5:  q = 5'd6;
            5'd6:  q = 5'd7;
            5'd7:  q = 5'd8;
            5'd8:  q = 5'd9;
            5'd9:  q = 5'd10;
            5'd10: q = 5'd11;
            5'd11: q = 5'd12;
            5'd12: q = 5'd13;
            5'd13: q = 5'd14;
            5'd14: q = 5'd15;
            5'd15: q = 5'd16;
            5'd16: q = 5'd17;
            5'd17: q = 5'd18;
            5'd18: q = 5'd19;
            5'd19: q = 5'd20;
            5'd20: q = 5'd21;
            5'd21: q = 5'd22;
            5'd22: q = 5'd23;
            5'd23: q = 5'd24;
            5'd24: q = 5'd25;
            5'd25: q = 5'd26;
            5'd26: q = 5'd27;
            5'd27: q = 5'd28;
            5'd28: q = 5'd29;
            5'd29: q = 5'd30;
            5'd30: q = 5'd31;
            5'd31: begin
                q = 5'd0;
                c = 1'b1;
            end
            default: begin
                q = 5'd0;
                c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/macro_fifo32_incr.sv
// -----------------------------------------------------------------------------
// macro_fifo32_incr
//   32-entry synchronous FIFO with first-word fall-through output and
//   valid/ready handshakes on both sides. Pointers are {wrap, ptr[4:0]}; the
//   5-bit part advances through macro_rom_incr5 and its carry toggles wrap.
//   Equal pointers with equal wrap bits mean empty, with differing wrap bits
//   mean full.
//
// Ports
//   clk      input                    rising-edge clock
//   resetn   input                    asynchronous active-low reset
//   flush    input                    synchronous flush, empties the FIFO
//   s_valid  input                    write side: data offered
//   s_ready  output                   write side: FIFO can accept (!full)
//   s_data   input  [DATA_WIDTH-1:0]  write side: entry to store
//   m_valid  output                   read side: head entry valid (!empty)
//   m_ready  input                    read side: consumer takes head entry
//   m_data   output [DATA_WIDTH-1:0]  read side: head entry (combinational)
//   count    output [5:0]             occupancy, 0..32
// -----------------------------------------------------------------------------
module macro_fifo32_incr #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [5:0]            count
);

    localparam int DEPTH = 32;
    localparam int PTR_W = 5;

    logic [PTR_W-1:0] wptr_q, wptr_d, wptr_inc;
    logic [PTR_W-1:0] rptr_q, rptr_d, rptr_inc;
    logic             wwrap_q, wwrap_d, wptr_carry;
    logic             rwrap_q, rwrap_d, rptr_carry;
    logic [PTR_W:0]   count_q, count_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic empty, full, push, pop;

    macro_rom_incr5 u_wptr_incr (
        .d (wptr_q),
        .q (wptr_inc),
        .c (wptr_carry)
    );

    macro_rom_incr5 u_rptr_incr (
        .d (rptr_q),
        .q (rptr_inc),
        .c (rptr_carry)
    );

    // Handshake flags depend only on registered pointer state.
    assign empty   = (rptr_q == wptr_q) && (rwrap_q == wwrap_q);
    assign full    = (rptr_q == wptr_q) && (rwrap_q != wwrap_q);
    assign s_ready = !full;
    assign m_valid = !empty;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    assign m_data = mem[rptr_q];
    assign count  = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        wwrap_d = wwrap_q;
        rptr_d  = rptr_q;
        rwrap_d = rwrap_q;
        count_d = count_q;

        if (flush) begin
            // A flush wins over any handshake in the same cycle.
            wptr_d  = '0;
            wwrap_d = 1'b0;
            rptr_d  = '0;
            rwrap_d = 1'b0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d  = wptr_inc;
                wwrap_d = wwrap_q ^ wptr_carry;
            end
            if (pop) begin
                rptr_d  = rptr_inc;
                rwrap_d = rwrap_q ^ rptr_carry;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            wwrap_q <= 1'b0;
            rptr_q  <= '0;
            rwrap_q <= 1'b0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            wwrap_q <= wwrap_d;
            rptr_q  <= rptr_d;
            rwrap_q <= rwrap_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; contents are only observable once
    // written, and leaving reset off lets it map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_macro_fifo32_incr.sv
// -----------------------------------------------------------------------------
// tb_macro_fifo32_incr
//   Directed bench for macro_fifo32_incr. A queue holds the entries the bench
//   expects to be stored; a model occupancy count predicts the flags. Inputs
//   change 1ns after the rising edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_macro_fifo32_incr;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [5:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb[$];
    int          mcount = 0;

    macro_fifo32_incr #(.DATA_WIDTH(64)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":m_valid"}, 64'(m_valid), 64'(mcount != 0));
        check({tag, ":s_ready"}, 64'(s_ready), 64'(mcount != 32));
        check({tag, ":count"},   64'(count),   64'(mcount));
        if (mcount != 0) check({tag, ":m_data"}, m_data, sb[0]);
    endtask

    // One clock cycle: drive inputs, compare outputs before the edge, update model.
    task automatic cycle(input string tag, input logic sv, input logic [63:0] sd,
                         input logic mr, input logic fl);
        bit do_push, do_pop;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        @(negedge clk);
        check_outputs(tag);
        do_push = sv && (mcount != 32);
        do_pop  = mr && (mcount != 0);
        if (fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
                mcount--;
            end
            if (do_push) begin
                sb.push_back(sd);
                mcount++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn  = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset values while held in reset.
        @(negedge clk);
        check_outputs("in_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) cycle("idle", 1'b0, 64'd0, 1'b0, 1'b0);

        // Fill with 0x00..0x1F, then try a 33rd push.
        for (int i = 0; i < 32; i++) cycle("fill", 1'b1, 64'(i), 1'b0, 1'b0);
        cycle("push_when_full", 1'b1, 64'hDEAD, 1'b0, 1'b0);
        cycle("full_hold", 1'b0, 64'd0, 1'b0, 1'b0);

        // Drain in order.
        for (int i = 0; i < 32; i++) cycle("drain", 1'b0, 64'd0, 1'b1, 1'b0);
        cycle("empty_after_drain", 1'b0, 64'd0, 1'b0, 1'b0);

        // Streaming across the 31 -> 0 rollover of both pointers.
        for (int i = 0; i < 40; i++)
            cycle("stream", 1'b1, 64'h1000 + 64'(i), (i != 0), 1'b0);
        cycle("stream_tail", 1'b0, 64'd0, 1'b1, 1'b0);
        cycle("stream_empty", 1'b0, 64'd0, 1'b0, 1'b0);

        // Full with push and pop together: only the pop happens.
        for (int i = 0; i < 32; i++)
            cycle("refill", 1'b1, {32'hCAFE0000, 32'(i)}, 1'b0, 1'b0);
        cycle("full_push_pop", 1'b1, 64'hBAD0, 1'b1, 1'b0);
        check("full_push_pop:count_31", 64'(count), 64'd31);
        for (int i = 0; i < 31; i++) cycle("drain2", 1'b0, 64'd0, 1'b1, 1'b0);

        // Empty with push and pop together: only the push happens.
        cycle("empty_push_pop", 1'b1, 64'h5A5A_0001, 1'b1, 1'b0);
        check("empty_push_pop:count_1", 64'(count), 64'd1);
        check("empty_push_pop:m_data", m_data, 64'h5A5A_0001);
        cycle("drain3", 1'b0, 64'd0, 1'b1, 1'b0);

        // Flush with 17 stored plus a concurrent push and pop.
        for (int i = 0; i < 17; i++) cycle("pre_flush", 1'b1, 64'h2000 + 64'(i), 1'b0, 1'b0);
        cycle("flush", 1'b1, 64'h2FFF, 1'b1, 1'b1);
        check("after_flush:count", 64'(count), 64'd0);
        check("after_flush:m_valid", 64'(m_valid), 64'd0);
        cycle("post_flush_push", 1'b1, 64'h3333, 1'b0, 1'b0);
        check("post_flush:head", m_data, 64'h3333);
        cycle("post_flush_pop", 1'b0, 64'd0, 1'b1, 1'b0);

        // Async reset mid-stream at count = 12.
        for (int i = 0; i < 12; i++) cycle("pre_reset", 1'b1, 64'h4000 + 64'(i), 1'b0, 1'b0);
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("pre_reset:count_12", 64'(count), 64'd12);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset:m_valid", 64'(m_valid), 64'd0);
        check("async_reset:s_ready", 64'(s_ready), 64'd1);
        check("async_reset:count",   64'(count),   64'd0);
        sb.delete();
        mcount = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycle("reset_push", 1'b1, 64'hA5, 1'b0, 1'b0);
        check("reset_push:m_data", m_data, 64'hA5);
        check("reset_push:count",  64'(count), 64'd1);
        cycle("final_pop", 1'b0, 64'd0, 1'b1, 1'b0);
        cycle("final_idle", 1'b0, 64'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/macro_fifo32_incr.md
Name: macro_fifo32_incr

Overview:
- 32-entry synchronous FIFO with first-word fall-through (FWFT) output and valid/ready handshakes on both sides.
- Read and write pointers advance through a 5-bit unsigned increment ROM; its carry-out toggles each pointer's wrap bit.
- Used as a generic buffer in the Taurus 3001 pipeline, e.g. fetch-to-decode and store-buffer staging.
- Pairs with the existing 5-bit decrement utilities, which serve down-counting credit logic.

Parameters:
- DATA_WIDTH, 64, width of each stored entry in bits.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; empties the FIFO.
- s_valid  input  1  write side: data offered.
- s_ready  output  1  write side: FIFO can accept.
- s_data  input  DATA_WIDTH  write side: entry to store.
- m_valid  output  1  read side: head entry valid.
- m_ready  input  1  read side: consumer accepts the head entry.
- m_data  output  DATA_WIDTH  read side: head entry.
- count  output  6  occupancy, 0..32.

Behaviour:
- Reset: clk is the single clock; resetn is asynchronous and active-low.
  - On assertion: rptr=0, wptr=0, both wrap bits=0, count=0, m_valid=0, s_ready=1.
  - Storage array is not reset.
- Pointer state: {wrap, ptr[4:0]}, one set for write and one for read.
  - next ptr = incr5(ptr).
  - incr5 carry-out (set only at ptr=31 -> 0) toggles wrap.
- Empty = (rptr==wptr) and (rwrap==wwrap).
- Full = (rptr==wptr) and (rwrap!=wwrap).
- s_ready = !full and m_valid = !empty. Both are combinational from registered state and never depend on s_valid or m_ready.
- Push = s_valid & s_ready. On the clock edge: mem[wptr] <= s_data, then wptr advances.
- Pop = m_valid & m_ready. On the clock edge: rptr advances.
- m_data = mem[rptr], combinational (FWFT).
  - Value is don't-care while m_valid=0.
  - Must be stable while m_valid=1 and m_ready=0.
- Latency: data pushed at edge N into an empty FIFO gives m_valid=1 and m_data=that data after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- count updates:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
  - Saturation is impossible by construction; count==32 iff full and count==0 iff empty.
- Simultaneous push and pop:
  - When neither full nor empty, both pointers advance and count is held.
  - When full, push is blocked (s_ready=0) and only the pop happens; there is no write-through.
  - When empty, pop is blocked (m_valid=0) and only the push happens.
- flush=1 at an edge:
  - Pointers, wrap bits and count go to 0.
  - Any push or pop in the same cycle is discarded.
  - s_ready and m_valid are not gated by flush in the flush cycle.
- Reset mid-operation: immediate return to the empty state, with stored entries lost. The first push after resetn rises lands in entry 0.
- Source contract: a producer holding s_valid=1 with s_ready=0 must hold s_data stable. The FIFO does not check this.

Decomposition:
- No shared package; the only constants are depth 32 and pointer width 5, kept local.
- Sub-module macro_rom_incr5, instantiated twice (write and read pointer):
  - Ports d[4:0], q[4:0], c.
  - q = d+1 mod 32; c=1 only for d=31.
  - Implemented as an explicit 32-entry case ROM with a default of 0.
- Storage: a plain reg array of 32 x DATA_WIDTH in the FIFO module, inferable as distributed RAM.

Test Plan:
- Reset then idle: after resetn release, m_valid=0, s_ready=1, count=0 for 10 cycles with no valid inputs.
- Fill: push 32 entries 0x00..0x1F with m_ready=0.
  - count reaches 32 and s_ready=0 in the cycle after the 32nd push.
  - A 33rd s_valid is not accepted.
- Drain and wrap: drain all 32 and check order 0x00..0x1F. Then push and pop 40 more entries streaming, so both pointers pass 31->0 and wrap bits toggle. Order must be preserved and count must never exceed 1.
- Full and empty corners:
  - Full with s_valid=1 and m_ready=1 -> one pop only, count 32->31.
  - Empty with both asserted -> one push only, count 0->1, and m_data is correct the next cycle.
- Flush: with 17 entries stored plus a concurrent push and pop, assert flush for one cycle.
  - Next cycle: count=0 and m_valid=0.
  - The next push reappears at the head.
- Async reset mid-stream: drop resetn between clock edges at count=12.
  - Outputs go to reset values without waiting for a clock edge.
  - After release, push 0xA5 -> m_data=0xA5 and count=1.
